band_level_mapper: RTL and testbench

//  Downstream stage of filter_bank: takes one frame of 40 x 16-bit mel band energies and converts each band to an LED bar height.
//  Per band: log2 approximation, then floor/shift/saturate, then decay smoothing, then peak-hold tracking.

---
 rtl/music_strip_pkg.sv | 40 ++++
 rtl/band_level_mapper_if.sv | 23 ++
 rtl/log2_approx.sv | 28 ++
 rtl/band_level_mapper.sv | 149 ++++++++++++++
 tb/tb_band_level_mapper.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/music_strip_pkg.sv
// Shared constants, FSM state type and the log-to-bar-height mapping for the
// music strip band level mapper.
package music_strip_pkg;

    localparam int NUM_BANDS   = 40;
    localparam int BAND_W      = 16;
    localparam int LOG_W       = 7;
    localparam int LEVEL_W     = 5;
    localparam int LEVEL_MAX   = 30;
    localparam int FLOOR_LOG   = 48;
    localparam int LEVEL_SHIFT = 1;
    localparam int DECAY_STEP  = 2;
    localparam int PEAK_HOLD   = 8;
    localparam int IDX_W       = $clog2(NUM_BANDS);
    localparam int HOLD_W      = $clog2(PEAK_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DRAIN,
        DONE
    } mapper_state_t;

    // Noise floor subtraction, scaling and saturation, computed in 8 bits so
    // nothing can wrap.
    function automatic logic [LEVEL_W-1:0] log_to_raw(input logic [LOG_W-1:0] lg);
        logic [7:0] ext;
        logic [7:0] scaled;
        ext = {1'b0, lg};
        if (ext <= 8'(FLOOR_LOG)) begin
            return '0;
        end
        scaled = (ext - 8'(FLOOR_LOG)) >> LEVEL_SHIFT;
        if (scaled > 8'(LEVEL_MAX)) begin
            return LEVEL_W'(LEVEL_MAX);
        end
        return LEVEL_W'(scaled);
    endfunction

endpackage

// File: rtl/band_level_mapper_if.sv
// Frame-in / levels-out handshake bundle between filter bank, mapper and LED driver.
interface band_level_mapper_if;
    import music_strip_pkg::*;

    logic [NUM_BANDS-1:0][BAND_W-1:0]  in;
    logic                              s_valid;
    logic                              s_ready;
    logic [NUM_BANDS-1:0][LEVEL_W-1:0] level;
    logic [NUM_BANDS-1:0][LEVEL_W-1:0] peak;
    logic                              m_valid;
    logic                              m_ready;

    modport slave (
        input  in, s_valid, m_ready,
        output s_ready, level, peak, m_valid
    );

    modport master (
        output in, s_valid, m_ready,
        input  s_ready, level, peak, m_valid
    );

endinterface

// File: rtl/log2_approx.sv
// Combinational log2 approximation: leading-one position in the upper bits,
// the three bits just below the leading one as a fraction.
module log2_approx
    import music_strip_pkg::*;
(
    input  logic [BAND_W-1:0] i_val,
    output logic [LOG_W-1:0]  o_log
);

    logic [3:0]        w_pos;
    logic [BAND_W+2:0] w_ext;
    logic [2:0]        w_frac;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < BAND_W; i++) begin
            if (i_val[i]) begin
                w_pos = 4'(i);
            end
        end
    end

    // Appending three zeros pads the fraction when the leading one sits below bit 3.
    assign w_ext  = {i_val, 3'b000};
    assign w_frac = 3'(w_ext >> w_pos);
    assign o_log  = (i_val == '0) ? '0 : {w_pos, w_frac};

endmodule

// File: rtl/band_level_mapper.sv
// Converts a frame of mel band energies into smoothed LED bar heights with
// peak-hold markers, one band per cycle through a two-stage pipe.
module band_level_mapper
    import music_strip_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    band_level_mapper_if.slave bus
);

    mapper_state_t r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic r_drain, w_drain_next;
    logic w_accept, w_issue;

    logic [NUM_BANDS-1:0][BAND_W-1:0] r_frame;
    logic [LOG_W-1:0] w_log, r_s1_log;
    logic [IDX_W-1:0] r_s1_idx;
    logic r_s1_vld;

    logic [NUM_BANDS-1:0][LEVEL_W-1:0] w_level_all, w_peak_all;
    logic [NUM_BANDS-1:0][HOLD_W-1:0]  w_hold_all;
    logic [LEVEL_W-1:0] w_raw, w_cur_level, w_cur_peak, w_dec, w_new_level, w_new_peak;
    logic [HOLD_W-1:0]  w_cur_hold, w_new_hold;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_drain_next = r_drain;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.s_valid) begin
                    w_accept     = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = PROC;
                end
            end
            PROC: begin
                w_issue    = 1'b1;
                w_idx_next = r_idx + IDX_W'(1);
                if (r_idx == IDX_W'(NUM_BANDS - 1)) begin
                    w_idx_next   = '0;
                    w_drain_next = 1'b0;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_drain_next = 1'b1;
                if (r_drain) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.m_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_drain  <= 1'b0;
            r_s1_vld <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_drain  <= w_drain_next;
            r_s1_vld <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame <= bus.in;
        end
        if (w_issue) begin
            r_s1_log <= w_log;
            r_s1_idx <= r_idx;
        end
    end

    log2_approx u_log2 (
        .i_val (r_frame[r_idx]),
        .o_log (w_log)
    );

    // Stage 2: map, decay-smooth and peak-track the band held in stage 1.
    always_comb begin
        w_raw       = log_to_raw(r_s1_log);
        w_cur_level = w_level_all[r_s1_idx];
        w_cur_peak  = w_peak_all[r_s1_idx];
        w_cur_hold  = w_hold_all[r_s1_idx];
        w_dec       = (w_cur_level >= LEVEL_W'(DECAY_STEP)) ?
                      w_cur_level - LEVEL_W'(DECAY_STEP) : '0;
        if (w_raw >= w_cur_level) begin
            w_new_level = w_raw;
        end else begin
            w_new_level = (w_raw > w_dec) ? w_raw : w_dec;
        end
        w_new_peak = w_cur_peak;
        w_new_hold = w_cur_hold;
        if (w_new_level >= w_cur_peak) begin
            w_new_peak = w_new_level;
            w_new_hold = HOLD_W'(PEAK_HOLD);
        end else if (w_cur_hold != '0) begin
            w_new_hold = w_cur_hold - HOLD_W'(1);
        end else begin
            w_new_peak = (w_new_level > w_cur_peak - LEVEL_W'(1)) ?
                         w_new_level : w_cur_peak - LEVEL_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            logic [LEVEL_W-1:0] r_level;
            logic [LEVEL_W-1:0] r_peak;
            logic [HOLD_W-1:0]  r_hold;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_level <= '0;
                    r_peak  <= '0;
                    r_hold  <= '0;
                end else if (r_s1_vld && (r_s1_idx == IDX_W'(gi))) begin
                    r_level <= w_new_level;
                    r_peak  <= w_new_peak;
                    r_hold  <= w_new_hold;
                end
            end

            assign w_level_all[gi] = r_level;
            assign w_peak_all[gi]  = r_peak;
            assign w_hold_all[gi]  = r_hold;
        end
    endgenerate

    assign bus.level   = w_level_all;
    assign bus.peak    = w_peak_all;
    assign bus.s_ready = (r_state == IDLE) && !reset;
    assign bus.m_valid = (r_state == DONE);

endmodule

// File: tb/tb_band_level_mapper.sv
// Directed bench for band_level_mapper: latency, level/peak trajectories,
// back-pressure, continuous upstream valid and mid-frame reset.
module tb_band_level_mapper;
    import music_strip_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    band_level_mapper_if bus ();

    band_level_mapper u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] l2_in;
    logic [6:0]  l2_out;

    log2_approx u_l2 (
        .i_val (l2_in),
        .o_log (l2_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < NUM_BANDS; i++) begin
            bus.in[i] = v;
        end
    endtask

    task automatic send_frame(output int lat);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("sready_timeout", 0, 1);
        step();
        bus.s_valid = 1'b0;
        lat = 0;
        while (!bus.m_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic ack();
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("sready_after_ack", int'(bus.s_ready), 1);
        check("mvalid_after_ack", int'(bus.m_valid), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stable;
        int seen;
        int cyc;
        int n_acc;
        int n_hs;
        int acc_t[4];
        logic [15:0] l2_vec[7];
        int l2_exp[7];
        int exp_lv[16];
        int exp_pk[16];
        logic [NUM_BANDS-1:0][LEVEL_W-1:0] lv_snap, pk_snap;

        l2_vec = '{16'h0001, 16'h0300, 16'h8000, 16'hFFFF, 16'h0000, 16'h0002, 16'h0007};
        l2_exp = '{0, 76, 120, 127, 0, 8, 22};
        exp_lv = '{28, 26, 24, 22, 20, 18, 16, 14, 12, 10, 8, 6, 4, 2, 0, 0};
        exp_pk = '{30, 30, 30, 30, 30, 30, 30, 30, 29, 28, 27, 26, 25, 24, 23, 22};

        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        fill(16'h0000);
        l2_in = '0;

        // Reset state
        repeat (3) step();
        check("rst_sready", int'(bus.s_ready), 0);
        check("rst_mvalid", int'(bus.m_valid), 0);
        check("rst_level0", int'(bus.level[0]), 0);
        check("rst_peak39", int'(bus.peak[39]), 0);
        reset = 1'b0;
        step();
        check("idle_sready", int'(bus.s_ready), 1);

        // log2 unit vectors
        for (int i = 0; i < 7; i++) begin
            l2_in = l2_vec[i];
            #1;
            check($sformatf("log2_%04h", l2_vec[i]), int'(l2_out), l2_exp[i]);
            $display("log2 0x%04h -> %0d", l2_vec[i], l2_out);
        end

        // Full-scale frame, then back-pressure
        fill(16'h8000);
        send_frame(lat);
        $display("frame 1: latency %0d level0 %0d peak0 %0d", lat, bus.level[0], bus.peak[0]);
        check("f1_latency", lat, 42);
        check("f1_level0", int'(bus.level[0]), 30);
        check("f1_level39", int'(bus.level[39]), 30);
        check("f1_peak0", int'(bus.peak[0]), 30);
        check("f1_peak39", int'(bus.peak[39]), 30);
        lv_snap = bus.level;
        pk_snap = bus.peak;
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.m_valid && !bus.s_ready && bus.level == lv_snap && bus.peak == pk_snap)
                stable++;
        end
        check("bp_hold_cycles", stable, 20);
        ack();

        // Silent frames: decay and peak-hold trajectory
        fill(16'h0000);
        for (int f = 0; f < 16; f++) begin
            send_frame(lat);
            $display("frame %0d: latency %0d level0 %0d peak0 %0d", f + 2, lat, bus.level[0], bus.peak[0]);
            check($sformatf("f%0d_latency", f + 2), lat, 42);
            check($sformatf("f%0d_level0", f + 2), int'(bus.level[0]), exp_lv[f]);
            check($sformatf("f%0d_peak0", f + 2), int'(bus.peak[0]), exp_pk[f]);
            check($sformatf("f%0d_level39", f + 2), int'(bus.level[39]), exp_lv[f]);
            check($sformatf("f%0d_peak39", f + 2), int'(bus.peak[39]), exp_pk[f]);
            ack();
        end

        // Continuous s_valid with m_ready high: one accept per 44 cycles
        fill(16'h8000);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        n_acc = 0;
        n_hs = 0;
        cyc = 0;
        while (n_acc < 4 && cyc < 400) begin
            if (bus.s_valid && bus.s_ready) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            if (bus.m_valid && bus.m_ready) n_hs++;
            step();
            cyc++;
        end
        bus.s_valid = 1'b0;
        while (n_hs < 4 && cyc < 600) begin
            if (bus.m_valid && bus.m_ready) n_hs++;
            step();
            cyc++;
        end
        bus.m_ready = 1'b0;
        $display("stream: %0d accepts, %0d handshakes", n_acc, n_hs);
        check("stream_accepts", n_acc, 4);
        for (int i = 1; i < 4; i++) begin
            if (i < n_acc) check($sformatf("stream_gap%0d", i), acc_t[i] - acc_t[i-1], 44);
        end
        check("stream_handshakes", n_hs, 4);
        check("stream_level0", int'(bus.level[0]), 30);

        // Reset in the middle of PROC
        send_frame_abort: begin
            bus.s_valid = 1'b1;
            cyc = 0;
            while (!bus.s_ready && cyc < 200) begin
                step();
                cyc++;
            end
            if (cyc >= 200) check("abort_sready_timeout", 0, 1);
            step();
            bus.s_valid = 1'b0;
            repeat (17) step();
        end
        check("abort_idx", int'(u_dut.r_idx), 17);
        reset = 1'b1;
        step();
        check("abort_sready", int'(bus.s_ready), 0);
        check("abort_mvalid", int'(bus.m_valid), 0);
        check("abort_level0", int'(bus.level[0]), 0);
        check("abort_peak0", int'(bus.peak[0]), 0);
        check("abort_level39", int'(bus.level[39]), 0);
        reset = 1'b0;
        step();
        check("abort_idle_sready", int'(bus.s_ready), 1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.m_valid) seen++;
            step();
        end
        $display("abort: m_valid cycles after reset %0d", seen);
        check("abort_no_mvalid", seen, 0);

        // Single mid-level band from a clean state
        fill(16'h0000);
        bus.in[7] = 16'h0300;
        send_frame(lat);
        $display("frame k=7: latency %0d level7 %0d peak7 %0d", lat, bus.level[7], bus.peak[7]);
        check("k7_latency", lat, 42);
        check("k7_level7", int'(bus.level[7]), 14);
        check("k7_peak7", int'(bus.peak[7]), 14);
        check("k7_level6", int'(bus.level[6]), 0);
        check("k7_level8", int'(bus.level[8]), 0);
        check("k7_peak8", int'(bus.peak[8]), 0);
        check("k7_level0", int'(bus.level[0]), 0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
